// File: rtl/axi3_slave_mem.sv
// AXI3 slave backed by a 16 x 32-bit register memory, with independent write and read FSMs.
// Optional SLVERR reporting on malformed write bursts is enabled by defining AXI_SLV_ERR_RESP_EN.
module axi3_slave_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  awid_i,
  input  logic [5:0]  awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [5:0]  araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  wstate_e     wstate_q, wstate_d;
  rstate_e     rstate_q, rstate_d;

  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];

  logic [3:0]  awid_q, awid_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;

  logic [3:0]  arid_q, arid_d;
  logic [5:0]  raddr_q, raddr_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [3:0]  rcnt_q, rcnt_d;

`ifdef AXI_SLV_ERR_RESP_EN
  logic [3:0]  wcnt_q, wcnt_d;
  logic [1:0]  bresp_q, bresp_d;
`endif

  // WID is accepted but deliberately ignored: only one write is ever outstanding.
  logic        unusedWid;
  assign unusedWid = ^wid_i;

  // WRAP blocks are (len+1)*step bytes; since len+1 is a power of two the block mask is len<<sz | step-1.
  function automatic logic [5:0] nextAddr(input logic [5:0] addr, input logic [2:0] size,
                                          input logic [3:0] len, input logic [1:0] burst);
    logic [1:0] sz;
    logic [5:0] step;
    logic [5:0] inc;
    logic [5:0] mask;
    sz   = (size > 3'd2) ? 2'd2 : size[1:0];
    step = 6'd1 << sz;
    inc  = addr + step;
    mask = ({2'b00, len} << sz) | (step - 6'd1);
    case (burst)
      2'b00:   nextAddr = addr;
      2'b10:   nextAddr = (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
                          ? ((addr & ~mask) | (inc & mask)) : inc;
      default: nextAddr = inc;
    endcase
  endfunction

  always_comb begin
    wstate_d  = wstate_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    mem_d     = mem_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
`ifdef AXI_SLV_ERR_RESP_EN
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
`endif
    case (wstate_q)
      W_IDLE: begin
        awready_o = !rst_i;
        if (awvalid_i && awready_o) begin
          awid_d   = awid_i;
          waddr_d  = awaddr_i;
          wlen_d   = awlen_i;
          wsize_d  = awsize_i;
          wburst_d = awburst_i;
`ifdef AXI_SLV_ERR_RESP_EN
          wcnt_d   = 4'd0;
`endif
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          for (int i = 0; i < 4; i++) begin
            if (wstrb_i[i]) begin
              mem_d[waddr_q[5:2]][8*i +: 8] = wdata_i[8*i +: 8];
            end
          end
          waddr_d = nextAddr(waddr_q, wsize_q, wlen_q, wburst_q);
`ifdef AXI_SLV_ERR_RESP_EN
          wcnt_d  = wcnt_q + 4'd1;
`endif
          if (wlast_i) begin
`ifdef AXI_SLV_ERR_RESP_EN
            bresp_d = ((wcnt_q != wlen_q) || (wsize_q > 3'd2)) ? 2'b10 : 2'b00;
`endif
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign bid_o = awid_q;
`ifdef AXI_SLV_ERR_RESP_EN
  assign bresp_o = bresp_q;
`else
  assign bresp_o = 2'b00;
`endif

  // RDATA is a combinational read of the register array, so a write committed on one edge shows up the next cycle.
  always_comb begin
    rstate_d  = rstate_q;
    arid_d    = arid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    rdata_o   = 32'd0;
    case (rstate_q)
      R_IDLE: begin
        arready_o = !rst_i;
        if (arvalid_i && arready_o) begin
          arid_d   = arid_i;
          raddr_d  = araddr_i;
          rlen_d   = arlen_i;
          rsize_d  = arsize_i;
          rburst_d = arburst_i;
          rcnt_d   = 4'd0;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rdata_o  = mem_q[raddr_q[5:2]];
        rlast_o  = (rcnt_q == rlen_q);
        if (rready_i) begin
          if (rlast_o) begin
            rstate_d = R_IDLE;
          end else begin
            raddr_d = nextAddr(raddr_q, rsize_q, rlen_q, rburst_q);
            rcnt_d  = rcnt_q + 4'd1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign rid_o   = arid_q;
  assign rresp_o = 2'b00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate_q <= W_IDLE;
      awid_q   <= 4'd0;
      waddr_q  <= 6'd0;
      wlen_q   <= 4'd0;
      wsize_q  <= 3'd0;
      wburst_q <= 2'd0;
`ifdef AXI_SLV_ERR_RESP_EN
      wcnt_q   <= 4'd0;
      bresp_q  <= 2'b00;
`endif
      for (int k = 0; k < 16; k++) begin
        mem_q[k] <= 32'd0;
      end
    end else begin
      wstate_q <= wstate_d;
      awid_q   <= awid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
`ifdef AXI_SLV_ERR_RESP_EN
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
`endif
      mem_q    <= mem_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstate_q <= R_IDLE;
      arid_q   <= 4'd0;
      raddr_q  <= 6'd0;
      rlen_q   <= 4'd0;
      rsize_q  <= 3'd0;
      rburst_q <= 2'd0;
      rcnt_q   <= 4'd0;
    end else begin
      rstate_q <= rstate_d;
      arid_q   <= arid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Self-checking bench for axi3_slave_mem: directed AXI3 bursts plus randomized traffic checked
// against a byte-array memory model.
module tb_axi3_slave_mem;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  awid_i;
  logic [5:0]  awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [3:0]  arid_i;
  logic [5:0]  araddr_i;
  logic [3:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;

  axi3_slave_mem dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk_i = ~clk_i;

  int          nChecks = 0;
  int          nFail   = 0;
  byte unsigned model [64];
  logic [31:0] wData [16];
  logic [3:0]  wStrb [16];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    awid_i = 0; awaddr_i = 0; awlen_i = 0; awsize_i = 0; awburst_i = 0; awvalid_i = 0;
    wid_i = 0; wdata_i = 0; wstrb_i = 0; wlast_i = 0; wvalid_i = 0; bready_i = 0;
    arid_i = 0; araddr_i = 0; arlen_i = 0; arsize_i = 0; arburst_i = 0; arvalid_i = 0;
    rready_i = 0;
  endtask

  // Next beat address from the burst rules, using plain integer arithmetic.
  function automatic int modelNext(int addr, int size, int len, int burst);
    int step;
    int total;
    int lower;
    step = 1 << ((size > 2) ? 2 : size);
    if (burst == 0) return addr;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = (len + 1) * step;
      lower = addr - (addr % total);
      return lower + ((addr - lower + step) % total);
    end
    return (addr + step) % 64;
  endfunction

  function automatic logic [31:0] modelWord(int addr);
    int b;
    b = (addr / 4) * 4;
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic writeBurst(input logic [3:0] id, input int addr, input int len, input int size,
                            input int burst, input int nBeats, input int bStall);
    int a;
    int t;
    logic [1:0] expResp;
    @(negedge clk_i);
    awid_i = id; awaddr_i = addr[5:0]; awlen_i = len[3:0]; awsize_i = size[2:0];
    awburst_i = burst[1:0]; awvalid_i = 1;
    t = 0;
    while (!awready_o && t < 50) begin @(negedge clk_i); t++; end
    checkOutput("aw_ready", 32'(awready_o), 32'd1);
    @(negedge clk_i);
    awvalid_i = 0;
    a = addr;
    for (int b = 0; b < nBeats; b++) begin
      wvalid_i = 1; wid_i = id; wdata_i = wData[b]; wstrb_i = wStrb[b];
      wlast_i = (b == nBeats - 1);
      t = 0;
      while (!wready_o && t < 50) begin @(negedge clk_i); t++; end
      checkOutput("w_ready", 32'(wready_o), 32'd1);
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) begin
        if (wStrb[b][i]) model[(a / 4) * 4 + i] = wData[b][8*i +: 8];
      end
      a = modelNext(a, size, len, burst);
      wvalid_i = 0; wlast_i = 0;
      if (b < nBeats - 1 && $urandom_range(3) == 0) @(negedge clk_i);
    end
`ifdef AXI_SLV_ERR_RESP_EN
    expResp = ((nBeats - 1) != len || size > 2) ? 2'b10 : 2'b00;
`else
    expResp = 2'b00;
`endif
    checkOutput("b_valid", 32'(bvalid_o), 32'd1);
    checkOutput("b_id", 32'(bid_o), 32'(id));
    checkOutput("b_resp", 32'(bresp_o), 32'(expResp));
    for (int k = 0; k < bStall; k++) begin
      @(negedge clk_i);
      checkOutput("b_hold_valid", 32'(bvalid_o), 32'd1);
      checkOutput("b_hold_id", 32'(bid_o), 32'(id));
      checkOutput("b_hold_resp", 32'(bresp_o), 32'(expResp));
    end
    bready_i = 1;
    @(negedge clk_i);
    bready_i = 0;
    checkOutput("b_done", 32'(bvalid_o), 32'd0);
    checkOutput("aw_ready_again", 32'(awready_o), 32'd1);
  endtask

  task automatic readBurst(input logic [3:0] id, input int addr, input int len, input int size,
                           input int burst, input int stallBeat);
    int a;
    int t;
    @(negedge clk_i);
    arid_i = id; araddr_i = addr[5:0]; arlen_i = len[3:0]; arsize_i = size[2:0];
    arburst_i = burst[1:0]; arvalid_i = 1;
    t = 0;
    while (!arready_o && t < 50) begin @(negedge clk_i); t++; end
    checkOutput("ar_ready", 32'(arready_o), 32'd1);
    @(negedge clk_i);
    arvalid_i = 0;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      checkOutput("r_valid", 32'(rvalid_o), 32'd1);
      checkOutput("r_data", rdata_o, modelWord(a));
      checkOutput("r_last", 32'(rlast_o), 32'(b == len));
      checkOutput("r_id", 32'(rid_o), 32'(id));
      checkOutput("r_resp", 32'(rresp_o), 32'd0);
      if (b == stallBeat) begin
        for (int k = 0; k < 3; k++) begin
          rready_i = 0;
          @(negedge clk_i);
          checkOutput("r_hold_data", rdata_o, modelWord(a));
          checkOutput("r_hold_last", 32'(rlast_o), 32'(b == len));
          checkOutput("r_hold_id", 32'(rid_o), 32'(id));
        end
      end
      rready_i = 1;
      @(negedge clk_i);
      rready_i = 0;
      a = modelNext(a, size, len, burst);
    end
    checkOutput("r_done", 32'(rvalid_o), 32'd0);
    checkOutput("ar_ready_again", 32'(arready_o), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len;
    int size;
    int burst;
    applyStimulus();
    for (int i = 0; i < 64; i++) model[i] = 8'd0;

    // Reset values
    rst_i = 1;
    #12;
    checkOutput("rst_awready", 32'(awready_o), 32'd0);
    checkOutput("rst_wready", 32'(wready_o), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid_o), 32'd0);
    checkOutput("rst_bid", 32'(bid_o), 32'd0);
    checkOutput("rst_bresp", 32'(bresp_o), 32'd0);
    checkOutput("rst_arready", 32'(arready_o), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("rst_rid", 32'(rid_o), 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    checkOutput("rst_rresp", 32'(rresp_o), 32'd0);
    checkOutput("rst_rlast", 32'(rlast_o), 32'd0);
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    checkOutput("post_rst_awready", 32'(awready_o), 32'd1);
    checkOutput("post_rst_arready", 32'(arready_o), 32'd1);

    // INCR write of four full words, B held for three cycles
    wData[0] = 32'h11; wData[1] = 32'h22; wData[2] = 32'h33; wData[3] = 32'h44;
    for (int i = 0; i < 4; i++) wStrb[i] = 4'hF;
    writeBurst(4'd5, 0, 3, 2, 1, 4, 3);

    // WRAP read from 0x08 over words 0-3 with a stall mid-burst
    readBurst(4'd9, 8, 3, 2, 2, 1);
    readBurst(4'd3, 0, 3, 2, 1, -1);

    // Partial strobe write to a zeroed word
    wData[0] = 32'hAABBCCDD; wStrb[0] = 4'b0101;
    writeBurst(4'd7, 20, 0, 2, 1, 1, 0);
    readBurst(4'd2, 20, 0, 2, 1, -1);

    // Early WLAST on beat 2 of a four-beat burst
    for (int i = 0; i < 3; i++) begin wData[i] = $urandom(); wStrb[i] = 4'hF; end
    writeBurst(4'd11, 32, 3, 2, 1, 3, 0);
    readBurst(4'd1, 32, 3, 2, 1, 2);

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(15); size = $urandom_range(3); burst = $urandom_range(3);
      for (int i = 0; i <= len; i++) begin
        wData[i] = $urandom(); wStrb[i] = 4'($urandom_range(15));
      end
      writeBurst(4'($urandom_range(15)), $urandom_range(63), len, size, burst, len + 1,
                 $urandom_range(2));
      len = $urandom_range(15); size = $urandom_range(3); burst = $urandom_range(3);
      readBurst(4'($urandom_range(15)), $urandom_range(63), len, size, burst,
                $urandom_range(20) - 4);
    end

    // Reset in the middle of a write burst
    @(negedge clk_i);
    awid_i = 4'd6; awaddr_i = 6'd0; awlen_i = 4'd7; awsize_i = 3'd2; awburst_i = 2'b01;
    awvalid_i = 1;
    @(negedge clk_i);
    awvalid_i = 0; wvalid_i = 1; wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1;
    #1;
    checkOutput("midrst_wready", 32'(wready_o), 32'd0);
    checkOutput("midrst_awready", 32'(awready_o), 32'd0);
    checkOutput("midrst_bvalid", 32'(bvalid_o), 32'd0);
    applyStimulus();
    for (int i = 0; i < 64; i++) model[i] = 8'd0;
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    checkOutput("midrst_idle_awready", 32'(awready_o), 32'd1);
    checkOutput("midrst_idle_wready", 32'(wready_o), 32'd0);
    readBurst(4'd4, 0, 15, 2, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
